// File: rtl/mem_pkg.sv
// Shared types and default sizes for the cache-to-memory arbiter.
// Owner encoding doubles as the round-robin "last owner" value.
package mem_pkg;

    localparam int ADDR_WIDTH       = 16;
    localparam int LINE_WIDTH       = 256;
    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-requester round-robin chooser: a lone petition wins outright,
// a tie goes to whoever was not served last.
module rr_pick
    import mem_pkg::*;
(
    input  logic iPetition,
    input  logic dPetition,
    input  logic lastOwner,
    output logic grant,
    output logic owner
);

    logic w_tie;

    assign w_tie = iPetition && dPetition;
    assign grant = iPetition || dPetition;
    assign owner = w_tie ? ~lastOwner : (dPetition ? OWN_D : OWN_I);

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low clear to zero.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction/data cache line transfers onto one req/ack memory port
// and returns the line with a one-cycle service pulse to the winning cache.
//
//   state | meaning
//   IDLE  | sample petitions, grant and latch the request
//   BUSY  | memReq held until memAck; read data captured on ack
//   RESP  | one-cycle ServiceReady pulse to the owner
//   TURN  | dead cycle so the served cache can drop its petition
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int addr_width       = ADDR_WIDTH,
    parameter int cache_line_width = LINE_WIDTH,
    parameter int line_offset_bits = LINE_OFFSET_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        iPetition,
    input  logic [addr_width-1:0]       iAddr,
    output logic                        iServiceReady,
    input  logic                        dPetition,
    input  logic [addr_width-1:0]       dAddr,
    input  logic                        dWe,
    input  logic [cache_line_width-1:0] dWData,
    output logic                        dServiceReady,
    output logic [cache_line_width-1:0] lineToCache,
    output logic                        memReq,
    output logic [addr_width-1:0]       memAddr,
    output logic                        memWe,
    output logic [cache_line_width-1:0] memWData,
    input  logic                        memAck,
    input  logic [cache_line_width-1:0] memRData
);

    state_t r_state;
    state_t w_next;

    logic                        w_grant;
    logic                        w_pick_owner;
    logic                        w_take;
    logic                        w_capture;
    logic                        w_we_in;
    logic [addr_width-1:0]       w_addr_in;
    logic [addr_width-1:0]       w_addr_mask;
    logic                        r_owner;
    logic                        r_we;
    logic [addr_width-1:0]       r_addr;
    logic [cache_line_width-1:0] r_wdata;
    logic [cache_line_width-1:0] r_line;

    // The latched owner is also the round-robin history; it clears to I.
    rr_pick u_pick (
        .iPetition (iPetition),
        .dPetition (dPetition),
        .lastOwner (r_owner),
        .grant     (w_grant),
        .owner     (w_pick_owner)
    );

    assign w_take      = (r_state == ST_IDLE) && w_grant;
    assign w_capture   = (r_state == ST_BUSY) && memAck && !r_we;
    assign w_we_in     = (w_pick_owner == OWN_D) && dWe;
    assign w_addr_in   = (w_pick_owner == OWN_D) ? dAddr : iAddr;
    assign w_addr_mask = {{(addr_width - line_offset_bits){1'b1}}, {line_offset_bits{1'b0}}};

    register #(.WIDTH(1)) u_owner (
        .clk(clk), .reset(reset), .i_en(w_take), .i_d(w_pick_owner), .o_q(r_owner)
    );

    register #(.WIDTH(1)) u_we (
        .clk(clk), .reset(reset), .i_en(w_take), .i_d(w_we_in), .o_q(r_we)
    );

    register #(.WIDTH(addr_width)) u_addr (
        .clk(clk), .reset(reset), .i_en(w_take), .i_d(w_addr_in), .o_q(r_addr)
    );

    register #(.WIDTH(cache_line_width)) u_wdata (
        .clk(clk), .reset(reset), .i_en(w_take), .i_d(dWData), .o_q(r_wdata)
    );

    register #(.WIDTH(cache_line_width)) u_line (
        .clk(clk), .reset(reset), .i_en(w_capture), .i_d(memRData), .o_q(r_line)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_next = ST_BUSY;
            ST_BUSY: if (memAck)  w_next = ST_RESP;
            ST_RESP: w_next = ST_TURN;
            ST_TURN: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign memReq        = (r_state == ST_BUSY);
    assign memAddr       = r_addr & w_addr_mask;
    assign memWe         = r_we;
    assign memWData      = r_wdata;
    assign lineToCache   = r_line;
    assign iServiceReady = (r_state == ST_RESP) && (r_owner == OWN_I);
    assign dServiceReady = (r_state == ST_RESP) && (r_owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts every output
// each cycle, and literal checks pin the key scenarios.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         iPetition = 1'b0;
    logic [15:0]  iAddr = '0;
    logic         iServiceReady;
    logic         dPetition = 1'b0;
    logic [15:0]  dAddr = '0;
    logic         dWe = 1'b0;
    logic [255:0] dWData = '0;
    logic         dServiceReady;
    logic [255:0] lineToCache;
    logic         memReq;
    logic [15:0]  memAddr;
    logic         memWe;
    logic [255:0] memWData;
    logic         memAck = 1'b0;
    logic [255:0] memRData = '0;

    int n_pass = 0;
    int n_total = 0;

    mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .iPetition     (iPetition),
        .iAddr         (iAddr),
        .iServiceReady (iServiceReady),
        .dPetition     (dPetition),
        .dAddr         (dAddr),
        .dWe           (dWe),
        .dWData        (dWData),
        .dServiceReady (dServiceReady),
        .lineToCache   (lineToCache),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memWe         (memWe),
        .memWData      (memWData),
        .memAck        (memAck),
        .memRData      (memRData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction model: edge count n, one in-flight transfer, next sampling edge m_free.
    int           n = 0;
    int           m_resp_edge = -10;
    int           m_free = 0;
    bit           m_active = 0;
    bit           m_owner = 0;
    bit           m_we = 0;
    logic [15:0]  m_addr = '0;
    logic [255:0] m_wdata = '0;
    logic [255:0] m_line = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_owner = 0; m_we = 0; m_addr = '0;
            m_wdata = '0; m_line = '0; m_resp_edge = -10; m_free = 0;
        end else begin
            n++;
            if (m_active) begin
                if (memAck) begin
                    m_active = 0;
                    if (!m_we) m_line = memRData;
                    m_resp_edge = n;
                    m_free = n + 3;
                end
            end else if (n >= m_free && (iPetition || dPetition)) begin
                if (iPetition && dPetition) m_owner = !m_owner;
                else m_owner = dPetition;
                m_addr  = (m_owner ? dAddr : iAddr) & 16'hFFF0;
                m_we    = m_owner && dWe;
                m_wdata = dWData;
                m_active = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("m_memReq", memReq, m_active);
            chk("m_memAddr", memAddr, m_addr);
            chk("m_memWe", memWe, m_we);
            chk("m_memWData", memWData, m_wdata);
            chk("m_line", lineToCache, m_line);
            chk("m_iSR", iServiceReady, (n == m_resp_edge) && !m_owner);
            chk("m_dSR", dServiceReady, (n == m_resp_edge) && m_owner);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int start);
        start = -1;
        for (int k = 0; k < 40; k++) begin
            if (memReq) begin
                start = n;
                return;
            end
            step();
        end
        chk("wait_req_timeout", 1'b0, 1'b1);
    endtask

    task automatic ack(input int lat, input logic [255:0] data);
        repeat (lat) step();
        memAck = 1'b1;
        memRData = data;
        step();
        memAck = 1'b0;
    endtask

    localparam logic [255:0] PAT_A = {16{16'hA5A1}};
    localparam logic [255:0] PAT_B = {8{32'hB00B_1E55}};
    localparam logic [255:0] PAT_C = {16{16'hC3C3}};
    localparam logic [255:0] PAT_E = {4{64'hE1E2_E3E4_E5E6_E7E8}};
    localparam logic [255:0] PAT_F = {16{16'hF00D}};
    localparam logic [255:0] PAT_G = {16{16'h6A6A}};
    localparam logic [255:0] PAT_H = {16{16'h4848}};

    int starts[3];
    logic [255:0] last_line;
    logic [255:0] ord_data[3];

    initial begin
        #2;
        chk("rst_memReq", memReq, 1'b0);
        chk("rst_memAddr", memAddr, 16'h0);
        chk("rst_line", lineToCache, 256'h0);
        chk("rst_sr", {iServiceReady, dServiceReady}, 2'b00);
        #20 reset = 1'b1;
        step();

        // single instruction miss
        iPetition = 1'b1; iAddr = 16'h1237;
        wait_req(starts[0]);
        chk("imiss_addr", memAddr, 16'h1230);
        chk("imiss_we", memWe, 1'b0);
        ack(3, PAT_A);
        chk("imiss_isr", iServiceReady, 1'b1);
        chk("imiss_dsr", dServiceReady, 1'b0);
        chk("imiss_line", lineToCache, PAT_A);
        step();
        iPetition = 1'b0;
        step();
        chk("imiss_pulse_once", iServiceReady, 1'b0);

        // contention after reset: D, I, D with L=2
        reset = 1'b0;
        step();
        reset = 1'b1;
        iPetition = 1'b1; iAddr = 16'h2222;
        dPetition = 1'b1; dAddr = 16'h4444; dWe = 1'b0;
        ord_data[0] = PAT_C; ord_data[1] = PAT_E; ord_data[2] = PAT_F;
        for (int g = 0; g < 3; g++) begin
            wait_req(starts[g]);
            chk("rr_addr", memAddr, (g == 1) ? 16'h2220 : 16'h4440);
            ack(2, ord_data[g]);
            chk("rr_isr", iServiceReady, g == 1);
            chk("rr_dsr", dServiceReady, g != 1);
        end
        chk("rr_gap0", starts[1] - starts[0], 6);
        chk("rr_gap1", starts[2] - starts[1], 6);
        last_line = PAT_F;
        iPetition = 1'b0; dPetition = 1'b0;
        step(); step();

        // write-back
        dPetition = 1'b1; dWe = 1'b1; dWData = PAT_B; dAddr = 16'h5555;
        wait_req(starts[0]);
        chk("wb_we", memWe, 1'b1);
        chk("wb_wdata", memWData, PAT_B);
        chk("wb_addr", memAddr, 16'h5550);
        step(); step();
        chk("wb_hold_req", memReq, 1'b1);
        chk("wb_hold_wdata", memWData, PAT_B);
        ack(1, PAT_C);
        chk("wb_dsr", dServiceReady, 1'b1);
        chk("wb_line_kept", lineToCache, last_line);
        step();
        dPetition = 1'b0; dWe = 1'b0; dWData = '0;
        step();
        chk("wb_pulse_once", dServiceReady, 1'b0);

        // petition dropped during BUSY
        iPetition = 1'b1; iAddr = 16'h0F0F;
        wait_req(starts[0]);
        step();
        iPetition = 1'b0;
        chk("drop_req_held", memReq, 1'b1);
        ack(2, PAT_E);
        chk("drop_isr", iServiceReady, 1'b1);
        chk("drop_line", lineToCache, PAT_E);
        step(); step();
        chk("drop_idle_req", memReq, 1'b0);
        step();
        chk("drop_no_regrant", memReq, 1'b0);

        // reset mid-transfer
        dPetition = 1'b1; dAddr = 16'h7777;
        wait_req(starts[0]);
        step();
        reset = 1'b0;
        #1;
        chk("rst_mid_req", memReq, 1'b0);
        chk("rst_mid_addr", memAddr, 16'h0);
        chk("rst_mid_line", lineToCache, 256'h0);
        dPetition = 1'b0;
        step(); step();
        reset = 1'b1;
        iPetition = 1'b1; iAddr = 16'h1111;
        dPetition = 1'b1; dAddr = 16'h3333;
        wait_req(starts[0]);
        chk("rst_mid_dfirst", memAddr, 16'h3330);
        ack(1, PAT_F);
        chk("rst_mid_dsr", dServiceReady, 1'b1);
        iPetition = 1'b0; dPetition = 1'b0;
        step(); step();

        // zero-latency ack
        dPetition = 1'b1; dAddr = 16'h0ABC;
        wait_req(starts[0]);
        ack(0, PAT_G);
        chk("l0_dsr", dServiceReady, 1'b1);
        chk("l0_line", lineToCache, PAT_G);
        dPetition = 1'b0;
        step(); step();

        // stray ack in IDLE
        memAck = 1'b1; memRData = PAT_H;
        step();
        memAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray_sr", {iServiceReady, dServiceReady}, 2'b00);
            chk("stray_req", memReq, 1'b0);
            step();
        end
        chk("stray_line", lineToCache, PAT_G);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates main-memory line transfers between the instruction cache and the data cache. Sits directly downstream of both caches: each cache raises a petition with a line address on a miss; the arbiter serialises them onto a single request/acknowledge memory port and returns the fetched line together with a one-cycle `memServiceReady` pulse to the winning cache. Data-cache write-backs use the same port.

## Interface
- `addr_width`, 16: address width of cache petitions and memory port.
- `cache_line_width`, 256: line width, 16 words of 16 bits.
- `line_offset_bits`, 4: low address bits cleared on `memAddr`; log2 of words per line.
---
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `iPetition`  in  1  instruction-cache miss request (`petitionToArb`).
- `iAddr`  in  addr_width  instruction-cache line address (`addrToArb`).
- `iServiceReady`  out  1  one-cycle pulse: the line on `lineToCache` is for the instruction cache.
- `dPetition`  in  1  data-cache request.
- `dAddr`  in  addr_width  data-cache line address.
- `dWe`  in  1  data-cache request is a write-back.
- `dWData`  in  cache_line_width  write-back line.
- `dServiceReady`  out  1  one-cycle pulse: data-cache request done.
- `lineToCache`  out  cache_line_width  registered line read from memory; shared by both caches.
- `memReq`  out  1  memory request, held until acknowledged.
- `memAddr`  out  addr_width  latched address with the low `line_offset_bits` bits forced to 0.
- `memWe`  out  1  latched write flag.
- `memWData`  out  cache_line_width  latched write-back line.
- `memAck`  in  1  one-cycle pulse: memory completes; read data valid this cycle.
- `memRData`  in  cache_line_width  line read from memory.

## Operation
- FSM states: IDLE, BUSY, RESP, TURN. Reset state is IDLE.
- **IDLE**
  - No grant when neither petition is high.
  - With one petition high, grant that requester.
  - With both high, grant the requester that was not granted last. The `lastOwner` register resets to I, so the first contention goes to D.
  - On a grant, latch owner, address, `dWe` (0 for I) and `dWData`, update `lastOwner`, and go to BUSY.
- **BUSY**
  - `memReq`=1; `memAddr`/`memWe`/`memWData` come from the latches and stay stable.
  - On `memAck`: when the latched write flag is 0, capture `memRData` into the line register; go to RESP.
- **RESP**
  - Assert the owner's `ServiceReady` for exactly one cycle.
  - `lineToCache` holds the captured line. On a write-back the line register is unchanged and the caller ignores it.
  - Go to TURN.
- **TURN**
  - One idle cycle with no grant, so the served cache can update its tag/valid registers and drop its petition.
  - Go to IDLE.
- Petitions sampled in IDLE only. Petition changes in BUSY/RESP/TURN are ignored.
- A petition dropped mid-transaction does not abort the transaction: the memory transfer completes and the `ServiceReady` pulse is still issued.
- An ungranted petition stays pending for as long as its cache holds it high. No queue.

## Timing
- Reset values:
  - `memReq`, `memWe`, `iServiceReady`, `dServiceReady` = 0.
  - `memAddr`, `memWData`, `lineToCache` = 0.
  - State = IDLE; `lastOwner` = I.
- Reset is asynchronous and may arrive mid-operation. All of the above clear immediately, `memReq` falls without waiting for `memAck`, and any `memAck` in that cycle is discarded.
- All outputs are registered or decoded from state only; no combinational path from petitions to outputs.
- Latency: petition high in IDLE at cycle 0, so BUSY begins cycle 1 with `memReq`=1. If `memAck` arrives at cycle 1+L, RESP and `ServiceReady` are at cycle 2+L, TURN at 3+L, IDLE at 4+L.
- The earliest next grant is sampled in the IDLE cycle and takes effect at 5+L.
- `memAck` in the same cycle as the first BUSY cycle (L=0) is legal.
- `memAck` outside BUSY is ignored.

## Structure
- Shared package `mem_pkg`:
  - FSM state encoding (2 bits).
  - Owner encoding (I=0, D=1).
  - Default line and address widths.
- One sub-module, `rr_pick`: a 2-input round-robin chooser. Inputs are `iPetition`, `dPetition` and `lastOwner`; outputs are `grant` and `owner`.
- The datapath latches reuse the existing `register` module with enable.

## Test plan
- **Single instruction miss:** `iPetition`=1, `iAddr`=0x1237, memory acks 3 cycles after `memReq` with `memRData`=pattern A.
  - `memAddr`=0x1230, `memWe`=0.
  - `iServiceReady` is a single pulse with `lineToCache`=A.
  - `dServiceReady` stays 0.
- **Simultaneous petitions after reset:** both petitions high, then both held.
  - D is granted first.
  - I is granted next, 4+L cycles after the D grant.
  - Order continues alternating D, I, D.
- **Write-back:** `dPetition`=1, `dWe`=1, `dWData`=B.
  - `memWe`=1 and `memWData`=B held until `memAck`.
  - `dServiceReady` pulses once.
  - `lineToCache` is unchanged.
- **Petition dropped:** `iPetition` deasserted during BUSY.
  - `memReq` is held until `memAck`.
  - `iServiceReady` still pulses once.
  - TURN is followed by IDLE.
- **Reset mid-transfer:** `reset`=0 in BUSY.
  - `memReq`=0 in the same cycle.
  - After reset is released, the next contention grants D first.
- **Zero-latency and stray acks:**
  - `memAck` in the first BUSY cycle gives RESP on the next cycle.
  - `memAck` pulsed while IDLE produces no `ServiceReady`.
